// File: rtl/seq_scan_ctrl_if.sv
// Handshake and detector-side signal bundle for seq_scan_ctrl.
// The hit_mask signal exists only when HIT_MASK_EN is defined.
interface seq_scan_ctrl_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 1),
   parameter int IDX_W = $clog2(WIDTH)
);
   logic             start;
   logic [WIDTH-1:0] data_in;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] hit_count;
   logic [IDX_W-1:0] first_hit_idx;
   logic             first_hit_valid;
   logic             det_clr;
   logic             det_w;
   logic             det_z;
`ifdef HIT_MASK_EN
   logic [WIDTH-1:0] hit_mask;

   modport master (
      output start, data_in, det_z,
      input  busy, done, hit_count, first_hit_idx, first_hit_valid, det_clr, det_w, hit_mask
   );
   modport slave (
      input  start, data_in, det_z,
      output busy, done, hit_count, first_hit_idx, first_hit_valid, det_clr, det_w, hit_mask
   );
`else
   modport master (
      output start, data_in, det_z,
      input  busy, done, hit_count, first_hit_idx, first_hit_valid, det_clr, det_w
   );
   modport slave (
      input  start, data_in, det_z,
      output busy, done, hit_count, first_hit_idx, first_hit_valid, det_clr, det_w
   );
`endif
endinterface

// File: rtl/seq_scan_ctrl.sv
// Sequences a run-length detector over a WIDTH-bit word, LSB first, and reports hits.
// Optional HIT_MASK_EN adds a per-bit hit_mask output.
module seq_scan_ctrl #(
   parameter int WIDTH   = 16,
   parameter int DET_LAT = 1,
   parameter int CNT_W   = $clog2(WIDTH + 1),
   parameter int IDX_W   = $clog2(WIDTH)
) (
   input  logic           sys_clock,
   input  logic           sys_reset,
   seq_scan_ctrl_if.slave scan
);
   // r_seq runs once across SHIFT and DRAIN, so it doubles as the global sample cycle k
   localparam int SEQ_W = $clog2(WIDTH + DET_LAT);
   localparam logic [SEQ_W-1:0] LAST_SHIFT   = SEQ_W'(WIDTH - 1);
   localparam logic [SEQ_W-1:0] LAST_SEQ     = SEQ_W'(WIDTH + DET_LAT - 1);
   localparam logic [SEQ_W-1:0] FIRST_SAMPLE = SEQ_W'(DET_LAT);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_shift;
   logic [SEQ_W-1:0] r_seq;
   logic [CNT_W-1:0] r_hit_count;
   logic [IDX_W-1:0] r_first_idx;
   logic             r_first_valid;
   logic             w_accept;
   logic             w_hit;
   logic [IDX_W-1:0] w_bit_idx;
   logic             w_busy;
   logic             w_done;
   logic             w_det_clr;
   logic             w_det_w;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clock) begin
      if (sys_reset) r_state <= S_IDLE;
      else           r_state <= w_next_state;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_busy       = 1'b1;
      w_done       = 1'b0;
      w_det_clr    = 1'b0;
      w_det_w      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (scan.start) w_next_state = S_CLEAR;
         end
         S_CLEAR: begin
            w_det_clr    = 1'b1;
            w_next_state = S_SHIFT;
         end
         S_SHIFT: begin
            w_det_w = r_shift[0];
            if (r_seq == LAST_SHIFT) w_next_state = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_seq == LAST_SEQ) w_next_state = S_DONE;
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   assign w_accept  = (r_state == S_IDLE) && scan.start;
   // The upper edge of the sampling window coincides with the last DRAIN cycle
   assign w_hit     = ((r_state == S_SHIFT) || (r_state == S_DRAIN)) &&
                      (r_seq >= FIRST_SAMPLE) && scan.det_z;
   assign w_bit_idx = IDX_W'(r_seq - FIRST_SAMPLE);

   always_ff @(posedge sys_clock) begin
      if (sys_reset) begin
         r_shift       <= '0;
         r_seq         <= '0;
         r_hit_count   <= '0;
         r_first_idx   <= '0;
         r_first_valid <= 1'b0;
      end else begin
         if (w_accept)                 r_shift <= scan.data_in;
         else if (r_state == S_SHIFT)  r_shift <= r_shift >> 1;

         if ((r_state == S_SHIFT) || (r_state == S_DRAIN)) r_seq <= r_seq + SEQ_W'(1);
         else                                              r_seq <= '0;

         if (w_accept) begin
            r_hit_count   <= '0;
            r_first_idx   <= '0;
            r_first_valid <= 1'b0;
         end else if (w_hit) begin
            r_hit_count <= r_hit_count + CNT_W'(1);
            if (!r_first_valid) begin
               r_first_idx   <= w_bit_idx;
               r_first_valid <= 1'b1;
            end
         end
      end
   end

`ifdef HIT_MASK_EN
   logic [WIDTH-1:0] r_hit_mask;

   always_ff @(posedge sys_clock) begin
      if (sys_reset)  r_hit_mask <= '0;
      else if (w_accept) r_hit_mask <= '0;
      else if (w_hit) r_hit_mask[w_bit_idx] <= 1'b1;
   end

   assign scan.hit_mask = r_hit_mask;
`endif

   assign scan.busy            = w_busy;
   assign scan.done            = w_done;
   assign scan.det_clr         = w_det_clr;
   assign scan.det_w           = w_det_w;
   assign scan.hit_count       = r_hit_count;
   assign scan.first_hit_idx   = r_first_idx;
   assign scan.first_hit_valid = r_first_valid;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl with a behavioural four-equal-bits detector.
// Expected results come from a window-based reference over the scanned word.
module tb_seq_scan_ctrl;
   localparam int WIDTH   = 16;
   localparam int DET_LAT = 1;
   localparam int LAT     = WIDTH + DET_LAT + 2;
   localparam int RUN     = 4;

   typedef struct {
      logic [WIDTH-1:0] word;
      int               acc;
      int               count;
      int               idx;
      bit               valid;
      logic [WIDTH-1:0] mask;
   } exp_t;

   logic sys_clock = 1'b0;
   logic sys_reset = 1'b1;
   int   cyc       = 0;
   int   checks    = 0;
   int   errors    = 0;
   int   free_cyc  = 0;
   bit   mon_en    = 1'b0;
   exp_t sb[$];

   seq_scan_ctrl_if #(.WIDTH(WIDTH)) scan ();

   seq_scan_ctrl #(.WIDTH(WIDTH), .DET_LAT(DET_LAT)) dut (
      .sys_clock (sys_clock),
      .sys_reset (sys_reset),
      .scan      (scan)
   );

   always #5 sys_clock = ~sys_clock;
   always @(posedge sys_clock) cyc <= cyc + 1;

   // Detector: Z=1 once the last RUN bits were equal, registered, cleared by det_clr
   int   det_run  = 0;
   int   det_next = 0;
   logic det_last = 1'b0;
   logic det_z_q  = 1'b0;
   always @(posedge sys_clock) begin
      if (scan.det_clr === 1'b1) begin
         det_run <= 0;
         det_z_q <= 1'b0;
      end else begin
         if (det_run != 0 && scan.det_w === det_last) det_next = (det_run < 8) ? det_run + 1 : det_run;
         else                                         det_next = 1;
         det_run  <= det_next;
         det_last <= scan.det_w;
         det_z_q  <= (det_next >= RUN);
      end
   end
   assign scan.det_z = det_z_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t ref_scan(input logic [WIDTH-1:0] w, input int acc);
      exp_t r;
      r.word = w; r.acc = acc; r.count = 0; r.idx = 0; r.valid = 1'b0; r.mask = '0;
      for (int i = RUN - 1; i < WIDTH; i++) begin
         bit same = 1'b1;
         for (int j = 1; j < RUN; j++) if (w[i-j] != w[i]) same = 1'b0;
         if (same) begin
            r.count++;
            r.mask[i] = 1'b1;
            if (!r.valid) begin r.valid = 1'b1; r.idx = i; end
         end
      end
      return r;
   endfunction

   // Monitor: per-cycle protocol expectations from the head entry, results at its done cycle
   int               off;
   logic             exp_b, exp_c, exp_w, exp_d;
   logic [WIDTH-1:0] mon_word;
   exp_t             e;
   always @(negedge sys_clock) begin
      if (mon_en) begin
         exp_b = 1'b0; exp_c = 1'b0; exp_w = 1'b0; exp_d = 1'b0; off = -1;
         if (sb.size() > 0) begin
            off      = cyc - sb[0].acc;
            mon_word = sb[0].word;
            exp_b    = (off >= 1 && off <= LAT);
            exp_c    = (off == 1);
            exp_d    = (off == LAT);
            if (off >= 2 && off < 2 + WIDTH) exp_w = mon_word[4'(off - 2)];
         end
         check("busy",    32'(scan.busy),    32'(exp_b));
         check("det_clr", 32'(scan.det_clr), 32'(exp_c));
         check("det_w",   32'(scan.det_w),   32'(exp_d ? 1'b0 : exp_w));
         check("done",    32'(scan.done),    32'(exp_d));
         if (off == LAT) begin
            e = sb.pop_front();
            check("hit_count",       32'(scan.hit_count),       32'(e.count));
            check("first_hit_idx",   32'(scan.first_hit_idx),   32'(e.idx));
            check("first_hit_valid", 32'(scan.first_hit_valid), 32'(e.valid));
`ifdef HIT_MASK_EN
            check("hit_mask",        32'(scan.hit_mask),        32'(e.mask));
            check("mask_popcount",   32'($countones(scan.hit_mask)), 32'(e.count));
`endif
         end
      end
   end

   task automatic step();
      @(negedge sys_clock);
      #1;
   endtask

   task automatic wait_free();
      while (cyc < free_cyc) step();
   endtask

   task automatic issue(input logic [WIDTH-1:0] w);
      scan.start   = 1'b1;
      scan.data_in = w;
      sb.push_back(ref_scan(w, cyc));
      free_cyc = cyc + LAT + 1;
   endtask

   task automatic run_scan(input logic [WIDTH-1:0] w, input bit noisy);
      wait_free();
      issue(w);
      step();
      for (int j = 1; j <= LAT; j++) begin
         scan.start   = noisy && (j == 1 || j == 9 || j >= LAT - 1 || $urandom_range(0, 1) == 1);
         scan.data_in = WIDTH'($urandom);
         step();
      end
      scan.start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int acc;
      logic [WIDTH-1:0] w;
      scan.start   = 1'b0;
      scan.data_in = '0;
      repeat (3) step();
      check("rst_busy",            32'(scan.busy),            32'(0));
      check("rst_done",            32'(scan.done),            32'(0));
      check("rst_hit_count",       32'(scan.hit_count),       32'(0));
      check("rst_first_hit_idx",   32'(scan.first_hit_idx),   32'(0));
      check("rst_first_hit_valid", 32'(scan.first_hit_valid), 32'(0));
      check("rst_det_clr",         32'(scan.det_clr),         32'(0));
      check("rst_det_w",           32'(scan.det_w),           32'(0));
`ifdef HIT_MASK_EN
      check("rst_hit_mask",        32'(scan.hit_mask),        32'(0));
`endif
      sys_reset = 1'b0;
      mon_en    = 1'b1;
      free_cyc  = cyc + 1;

      run_scan(16'h0000, 1'b0);
      run_scan(16'h00FF, 1'b0);
      run_scan(16'hAAAA, 1'b0);

      // start held high across a whole scan: second word accepted only after done
      wait_free();
      issue(16'hFFFF);
      acc = cyc;
      step();
      scan.data_in = 16'hAAAA;
      while (cyc < acc + LAT + 1) step();
      check("b2b_held_count", 32'(scan.hit_count),       32'(13));
      check("b2b_held_valid", 32'(scan.first_hit_valid), 32'(1));
      issue(16'hAAAA);
      step();
      scan.start = 1'b0;
      check("b2b_cleared_count", 32'(scan.hit_count), 32'(0));

      // reset during SHIFT bit 7 aborts the scan with no done
      wait_free();
      issue(16'h0000);
      acc = cyc;
      step();
      scan.start = 1'b0;
      while (cyc < acc + 9) step();
      sys_reset = 1'b1;
      sb.delete();
      free_cyc = cyc + 2;
      step();
      check("abort_busy",      32'(scan.busy),            32'(0));
      check("abort_done",      32'(scan.done),            32'(0));
      check("abort_count",     32'(scan.hit_count),       32'(0));
      check("abort_valid",     32'(scan.first_hit_valid), 32'(0));
      sys_reset = 1'b0;
      run_scan(16'h0000, 1'b0);

      run_scan(16'h00FF, 1'b1);

      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 2))
            0:       w = WIDTH'($urandom);
            1:       w = WIDTH'($urandom & $urandom);
            default: w = WIDTH'($urandom | $urandom);
         endcase
         run_scan(w, ($urandom_range(0, 1) == 1));
      end

      for (int g = 0; g < 4 * LAT && sb.size() > 0; g++) step();
      check("scoreboard_drained", 32'(sb.size()), 32'(0));
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
